mux_sel_reg: RTL and testbench
==============================

Name: mux_sel_reg

Overview:
- Parametrised, registered successor to the fixed 8:1 combinational operand mux used in the ALU datapath.
- Selects one of CH channels of width N, using either a direct binary select or a round-robin scan of the valid channels.
- Holds the chosen word in a one-entry output register with valid/ready handshake.
- Sits between the ALU operand sources and the ALU input stage; absorbs downstream stalls and reports which channel was taken.

Parameters:
- N, 5, data width per channel.
- CH, 8, channel count; power of two, minimum 2.
- CW, 16, width of the transfer counter.
- SELW, clog2(CH), localparam; select and channel-ID width. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CH*N  flattened channel data; channel i occupies bits [i*N+N-1 : i*N].
- in_valid  input  CH  per-channel valid.
- in_ready  output  CH  per-channel ready; at most one bit high per cycle.
- sel  input  SELW  channel select, used in fixed mode.
- mode  input  1  0 = MODE_FIXED, 1 = MODE_RR.
- out_data  output  N  registered selected word.
- out_ch  output  SELW  source channel of out_data.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  downstream accepts the word.
- xfer_cnt  output  CW  count of completed output transfers.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, xfer_cnt=0, rr_ptr=0.
  - Any held word is discarded; there is no other reset state.
- Load condition: load = ~out_valid | out_ready. The register is either empty or draining this cycle.
- MODE_FIXED:
  - in_ready[i] = load && (i==sel). Ready does not depend on in_valid.
  - Grant occurs when in_valid[sel] && load; the granted channel g = sel.
- MODE_RR:
  - Scan from rr_ptr upward, modulo CH; the first channel with in_valid set is the winner g.
  - in_ready[g] = load; all other ready bits are 0.
  - If no channel is valid, all ready bits are 0 and there is no grant.
  - On a grant, rr_ptr <= (g+1) mod CH, wrapping from CH-1 to 0.
  - Without a grant, rr_ptr holds.
- rr_ptr behaviour in MODE_FIXED: it holds and does not advance.
- Grant (next edge): out_data <= channel g data, out_ch <= g, out_valid <= 1.
- No grant, out_ready=1: out_valid <= 0. out_data and out_ch hold their previous values.
- No grant, out_ready=0: all output-register state holds. out_data must not change while out_valid && !out_ready.
- Latency: one cycle from the input handshake to out_valid.
  - Full throughput (one word per cycle) with out_ready held at 1.
  - Back-to-back transfers work: when out_valid && out_ready coincide with a new grant, the register reloads in the same edge without a bubble.
- xfer_cnt increments on every cycle with out_valid && out_ready. It wraps from 2^CW-1 to 0.
- Mode or sel changes take effect in the same cycle. A word already held is unaffected.
- An out-of-range sel cannot occur because CH is a power of two.
- Simultaneous rst with a grant: reset wins.
- in_valid is ignored for unselected or non-winning channels. Those channels must hold their data until they are granted.

Decomposition:
- Shared package (alu_pkg): MODE_FIXED=1'b0 and MODE_RR=1'b1.
- SELW is a localparam computed in the block with $clog2.
- Sub-module mux_rr_pick: combinational rotate-priority picker.
  - Inputs: valid[CH] and ptr[SELW].
  - Outputs: any and idx[SELW].
- The data select, output register, pointer and counter live in mux_sel_reg.

Test Plan:
- Reset: assert rst for 2 cycles with all channels valid → out_valid=0, xfer_cnt=0, in_ready=0 during reset. After release in MODE_FIXED with sel=3 and ch3=5'h13: out_data=5'h13 and out_ch=3 one cycle later.
- Fixed mode, stall: sel=5, ch5=5'h0A, out_ready=0 for 4 cycles → out_valid=1, out_data stays 5'h0A, in_ready=0 after the first load. Then out_ready=1 → xfer_cnt=1.
- Round-robin fairness: mode=1, channels 1, 4 and 6 valid continuously, out_ready=1 → out_ch sequence 1, 4, 6, 1, 4, 6 on consecutive cycles, with rr_ptr wrapping past 7.
- Round-robin idle and wrap: only ch7 valid, rr_ptr=0 → g=7 and rr_ptr becomes 0. With no valid channels: in_ready=0, out_valid falls to 0, rr_ptr unchanged.
- Full throughput: mode=0, in_valid and out_ready held at 1 for 20 cycles → 20 consecutive out_valid cycles and xfer_cnt=20.
- Reset mid-operation and counter wrap: CW=4, complete 17 transfers → xfer_cnt=1. Assert rst while out_valid=1 → next cycle out_valid=0 and the held word is dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU operand path.
//   MODE_FIXED : operand taken from the channel named by sel.
//   MODE_RR    : operand taken from the next valid channel in round-robin order.
package alu_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick
//   Combinational rotate-priority picker. Starting at ptr and scanning upward
//   (modulo CH), returns the first channel whose valid bit is set.
//   Ports:
//     valid [CH]   per-channel request
//     ptr   [SELW] highest-priority channel this cycle
//     any          at least one channel is valid
//     idx   [SELW] winning channel (0 when any=0)
module mux_rr_pick #(
   parameter  int CH   = 8,
   localparam int SELW = $clog2(CH)
) (
   input  logic [CH-1:0]   valid,
   input  logic [SELW-1:0] ptr,
   output logic            any,
   output logic [SELW-1:0] idx
);

   // Walk offsets from farthest to nearest so the nearest valid channel
   // overwrites the others. The SELW-bit sum wraps naturally since CH is a
   // power of two.
   always_comb begin
      idx = '0;
      for (int k = CH-1; k >= 0; k--) begin
         if (valid[ptr + SELW'(k)])
            idx = ptr + SELW'(k);
      end
   end

   assign any = |valid;

endmodule

// File: rtl/mux_sel_reg.sv
// mux_sel_reg
//   Registered CH:1 operand mux with valid/ready handshake feeding the ALU
//   input stage. Channel choice is either the direct select (MODE_FIXED) or a
//   round-robin scan of valid channels (MODE_RR). The chosen word is held in a
//   single output register that reloads back-to-back while draining.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     in_data  [CH*N]   flattened channel data, channel i at [i*N +: N]
//     in_valid [CH]     per-channel valid
//     in_ready [CH]     per-channel ready, one-hot or zero
//     sel      [SELW]   channel select for MODE_FIXED
//     mode              MODE_FIXED / MODE_RR
//     out_data [N]      held word
//     out_ch   [SELW]   source channel of out_data
//     out_valid         out_data holds a word
//     out_ready         downstream accepts the word
//     xfer_cnt [CW]     completed output transfers, wrapping
module mux_sel_reg
   import alu_pkg::*;
#(
   parameter  int N    = 5,
   parameter  int CH   = 8,
   parameter  int CW   = 16,
   localparam int SELW = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH*N-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   input  logic [SELW-1:0]   sel,
   input  logic              mode,
   output logic [N-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW-1:0]     xfer_cnt
);

   logic [CH-1:0][N-1:0] ch_data;
   logic [SELW-1:0]      rr_ptr;
   logic [SELW-1:0]      rr_idx;
   logic                 rr_any;
   logic [SELW-1:0]      g;
   logic                 load;
   logic                 grant;

   assign ch_data = in_data;

   mux_rr_pick #(.CH(CH)) u_pick (
      .valid (in_valid),
      .ptr   (rr_ptr),
      .any   (rr_any),
      .idx   (rr_idx)
   );

   // The register can take a word when empty or draining. Reset masks the
   // handshake so no source believes it was accepted during reset.
   always_comb begin
      load     = ~rst & (~out_valid | out_ready);
      in_ready = '0;
      g        = sel;
      grant    = 1'b0;
      if (mode == MODE_RR) begin
         g     = rr_idx;
         grant = load & rr_any;
         if (grant)
            in_ready[rr_idx] = 1'b1;
      end else begin
         // Fixed mode offers ready on sel regardless of its valid.
         grant = load & in_valid[sel];
         if (load)
            in_ready[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         xfer_cnt  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (grant) begin
            out_data  <= ch_data[g];
            out_ch    <= g;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready)
            xfer_cnt <= xfer_cnt + 1'b1;
         // Pointer moves past the winner; SELW-bit add wraps CH-1 -> 0.
         if (grant && mode == MODE_RR)
            rr_ptr <= rr_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_sel_reg.sv
// tb_mux_sel_reg
//   Directed plus randomized bench for mux_sel_reg. A transaction-level model
//   (held word, source channel, scan pointer, unbounded transfer count)
//   predicts every cycle. A second instance with CW=4 exercises counter wrap.
module tb_mux_sel_reg;

   localparam int N    = 5;
   localparam int CH   = 8;
   localparam int SELW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH*N-1:0]   in_data;
   logic [CH-1:0]     in_valid;
   logic [SELW-1:0]   sel;
   logic              mode;
   logic              out_ready;

   logic [CH-1:0]     in_ready,  in_ready4;
   logic [N-1:0]      out_data,  out_data4;
   logic [SELW-1:0]   out_ch,    out_ch4;
   logic              out_valid, out_valid4;
   logic [15:0]       xfer_cnt;
   logic [3:0]        xfer_cnt4;

   int npass = 0;
   int nchk  = 0;

   // reference model state
   bit         m_valid = 0;
   logic [N-1:0] m_data = '0;
   int         m_ch  = 0;
   int         m_ptr = 0;
   int         m_cnt = 0;

   always #5 clk = ~clk;

   mux_sel_reg #(.N(N), .CH(CH), .CW(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
      .xfer_cnt(xfer_cnt)
   );

   mux_sel_reg #(.N(N), .CH(CH), .CW(4)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready4), .sel(sel), .mode(mode), .out_data(out_data4),
      .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready),
      .xfer_cnt(xfer_cnt4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic setch(input int c, input logic [N-1:0] v);
      in_data[c*N +: N] = v;
   endtask

   task automatic rand_data();
      for (int c = 0; c < CH; c++) setch(c, N'($urandom_range(31)));
   endtask

   // One clock: predict and check ready before the edge, advance the model
   // at the edge, check the registered outputs just after it.
   task automatic cycle();
      bit           ld, grant;
      int           g, bestd, d;
      logic [CH-1:0] er;
      #1;
      ld    = !rst && (!m_valid || out_ready);
      er    = '0;
      grant = 0;
      g     = 0;
      if (mode == 1'b0) begin
         g = int'(sel);
         if (ld) er[g] = 1'b1;
         grant = ld && in_valid[g];
      end else begin
         // winner = valid channel at the smallest forward distance from ptr
         bestd = CH;
         for (int c = 0; c < CH; c++) begin
            d = (c - m_ptr + CH) % CH;
            if (in_valid[c] && d < bestd) begin
               bestd = d;
               g     = c;
            end
         end
         grant = ld && (bestd < CH);
         if (grant) er[g] = 1'b1;
      end
      chk("in_ready",  64'(in_ready),  64'(er));
      chk("in_ready4", 64'(in_ready4), 64'(er));
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (m_valid && out_ready) m_cnt++;
         if (grant) begin
            m_data  = in_data[g*N +: N];
            m_ch    = g;
            m_valid = 1;
            if (mode) m_ptr = (g + 1) % CH;
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data",  64'(out_data),  64'(m_data));
      chk("out_ch",    64'(out_ch),    64'(m_ch));
      chk("xfer_cnt",  64'(xfer_cnt),  64'(m_cnt % 65536));
      chk("out_data4", 64'(out_data4), 64'(m_data));
      chk("xfer_cnt4", 64'(xfer_cnt4), 64'(m_cnt % 16));
   endtask

   initial begin
      // reset with every channel valid
      rst = 1; mode = 0; sel = 0; out_ready = 0; in_valid = '1;
      rand_data();
      repeat (2) cycle();

      // first load after reset: ch3 = 5'h13
      rst = 0; sel = 3; setch(3, 5'h13); out_ready = 1;
      cycle();
      chk("first_load_data", 64'(out_data), 64'h13);
      chk("first_load_ch",   64'(out_ch),   64'd3);

      // fixed-mode stall on ch5 = 5'h0A
      sel = 5; setch(5, 5'h0A);
      cycle();
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         rand_data(); setch(5, 5'h0A);
         cycle();
      end
      chk("stall_hold", 64'(out_data), 64'h0A);
      out_ready = 1;
      repeat (2) cycle();

      // round-robin fairness on channels 1, 4, 6
      mode = 1; in_valid = 8'b0101_0010;
      for (int i = 0; i < 6; i++) begin
         rand_data();
         cycle();
         chk("rr_order", 64'(out_ch), 64'(i % 3 == 0 ? 1 : (i % 3 == 1 ? 4 : 6)));
      end

      // only ch7, then nothing valid
      in_valid = 8'h80;
      repeat (2) cycle();
      in_valid = '0;
      repeat (2) cycle();
      chk("rr_idle_empty", 64'(out_valid), 64'd0);

      // full throughput in fixed mode
      mode = 0; in_valid = '1; out_ready = 1;
      for (int i = 0; i < 20; i++) begin
         rand_data(); sel = SELW'($urandom_range(CH-1));
         cycle();
      end

      // reset, 17 transfers to wrap the 4-bit counter, then reset a held word
      rst = 1; cycle(); rst = 0;
      for (int i = 0; i < 18; i++) begin
         rand_data();
         cycle();
      end
      chk("wrap4", 64'(xfer_cnt4), 64'd1);
      out_ready = 0; cycle();
      rst = 1; cycle();
      rst = 0; in_valid = '0; cycle();
      chk("rst_drop", 64'(out_valid), 64'd0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         rand_data();
         rst       = ($urandom_range(39) == 0);
         mode      = 1'($urandom_range(1));
         sel       = SELW'($urandom_range(CH-1));
         in_valid  = CH'($urandom_range(255));
         out_ready = ($urandom_range(3) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
